fetch_predict_unit: RTL and testbench
=====================================

# fetch_predict_unit

Parametrised instruction-fetch front end for the MIPS core. Holds the program counter and drives the instruction-cache request. Predicts the next PC through a direct-mapped branch target buffer (BTB) with saturating counters, and redirects on mispredicts reported by the execute stage. Sits between the instruction side of `datapath_cache_if` and the decode stage, and replaces the flat pc/next_pc logic of the single-cycle datapath.

## Interface
Parameters:
- PC_INIT, 32'h0, program counter value loaded at reset
- BTB_ENTRIES, 16, number of BTB entries; power of two, 2..256; IDX = log2(BTB_ENTRIES)
- CTR_BITS, 2, width of each saturating direction counter, 1..4

Ports (reset nRST, asynchronous, active-low; clock CLK):
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction returned for imemaddr this cycle
- stall  in  1  downstream stall; hold the PC
- halt_in  in  1  halt decoded
- rslv_valid  in  1  a branch or jump resolved this cycle
- rslv_pc  in  32  PC of the resolved instruction
- rslv_taken  in  1  resolved direction
- rslv_target  in  32  resolved taken target
- rslv_mispredict  in  1  front end must redirect
- rslv_next  in  32  correct next PC after the resolved instruction
- imemaddr  out  32  current PC
- imemREN  out  1  fetch enable
- pred_taken  out  1  prediction for the current PC
- pred_target  out  32  predicted target (0 when not taken)
- halt  out  1  sticky halt
- br_count  out  32  resolved-branch count
- mp_count  out  32  mispredict count

## Operation
BTB entry fields: valid, tag = pc[31:IDX+2], target[31:0], ctr[CTR_BITS-1:0]. Index = pc[IDX+1:2]. pc[1:0] is ignored everywhere.

Lookup (combinational on imemaddr):
- pred_taken = valid & tag match & ctr MSB.
- pred_target = entry target when pred_taken, else 0.

Next-PC priority, evaluated at each posedge:
1. halt = 1: hold PC.
2. rslv_valid & rslv_mispredict: PC <= rslv_next. This ignores ihit and stall.
3. ihit & ~stall: PC <= pred_taken ? pred_target : PC+4. PC+4 wraps modulo 2^32.
4. Otherwise: hold PC.

BTB update, when rslv_valid & ~halt:
- On a hit (valid and tag match at index(rslv_pc)):
  - ctr increments if taken, decrements if not, saturating at 0 and 2^CTR_BITS-1.
  - target <= rslv_target if taken.
- On a miss with rslv_taken = 1: allocate or overwrite the entry. Set valid = 1, tag, target, and ctr = 2^(CTR_BITS-1) (weakly taken).
- On a miss with rslv_taken = 0: no change.

Counters:
- br_count increments on rslv_valid & ~halt.
- mp_count increments on rslv_valid & rslv_mispredict & ~halt.
- Both saturate at 32'hFFFF_FFFF.

Halt: halt <= 1 on any cycle with halt_in = 1. It stays set until reset. imemREN = ~halt.

## Timing
Reset values:
- imemaddr = PC_INIT
- halt = 0
- imemREN = 1
- br_count = mp_count = 0
- all BTB valid = 0, ctr = 2^(CTR_BITS-1)-1
- pred_taken = 0, pred_target = 0

Latency:
- Prediction is 0-cycle combinational from imemaddr.
- PC update takes effect 1 cycle after the qualifying edge.

Simultaneous events:
- A BTB write is visible to lookups in the cycle after the edge. If the same-index lookup happens in the same cycle as the write, it sees the old contents.
- Mispredict redirect and ihit in the same cycle: the redirect wins, and the fetched instruction is discarded by decode.
- halt_in and mispredict in the same cycle: the redirect is applied, halt sets, and the PC freezes from the next edge.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous).

## Test plan
- Reset, then ihit=1 for 4 cycles, stall=0 -> imemaddr 0,4,8,12,16; pred_taken=0; imemREN=1.
- ihit=1 with stall=1 for 3 cycles at PC 0x20 -> imemaddr stays 0x20; deassert stall -> 0x24.
- Resolve pc=0x40 taken to 0x100 with mispredict, rslv_next=0x100 -> next cycle imemaddr=0x100, mp_count=1, br_count=1. Fetching 0x40 later -> pred_taken=1, pred_target=0x100; with ihit the following PC is 0x100.
- Counter hysteresis, BTB_ENTRIES=16, CTR_BITS=2: after allocating 0x40, resolve not-taken twice -> first not-taken leaves pred_taken=0 (ctr 1), second leaves ctr 0; one taken -> ctr 1, still not taken; second taken -> ctr 2, predicted taken.
- Aliasing: allocate 0x40, then fetch 0x80 (same index, different tag) -> pred_taken=0. Allocate 0x80 -> fetching 0x40 now misses.
- halt_in pulse at PC 0x30 -> halt=1, imemREN=0 next cycle; imemaddr frozen at its post-edge value despite ihit and mispredicts; br_count unchanged afterwards; nRST low -> all outputs return to reset values.

Source files
------------

// File: rtl/fetch_predict_unit.sv
// Instruction-fetch front end: owns the PC, drives the I-cache request and
// predicts the next PC from a direct-mapped BTB with saturating counters.
module fetch_predict_unit #(
   parameter logic [31:0] PC_INIT     = 32'h0,
   parameter int          BTB_ENTRIES = 16,
   parameter int          CTR_BITS    = 2
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic        stall,
   input  logic        halt_in,
   input  logic        rslv_valid,
   input  logic [31:0] rslv_pc,
   input  logic        rslv_taken,
   input  logic [31:0] rslv_target,
   input  logic        rslv_mispredict,
   input  logic [31:0] rslv_next,
   output logic [31:0] imemaddr,
   output logic        imemREN,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   output logic        halt,
   output logic [31:0] br_count,
   output logic [31:0] mp_count
);

   localparam int IDX   = $clog2(BTB_ENTRIES);
   localparam int TAG_W = 30 - IDX;
   localparam logic [CTR_BITS-1:0] CTR_MAX    = '1;
   localparam logic [CTR_BITS-1:0] CTR_WEAK_T = CTR_BITS'(2 ** (CTR_BITS - 1));
   localparam logic [CTR_BITS-1:0] CTR_WEAK_N = CTR_BITS'(2 ** (CTR_BITS - 1) - 1);

   logic                btb_valid  [BTB_ENTRIES];
   logic [TAG_W-1:0]    btb_tag    [BTB_ENTRIES];
   logic [31:0]         btb_target [BTB_ENTRIES];
   logic [CTR_BITS-1:0] btb_ctr    [BTB_ENTRIES];

   logic [IDX-1:0]      fetch_idx;
   logic [TAG_W-1:0]    fetch_tag;
   logic [IDX-1:0]      rslv_idx;
   logic [TAG_W-1:0]    rslv_tag;
   logic                rslv_hit;
   logic                update_en;
   logic [CTR_BITS-1:0] ctr_next;
   logic                unused_bits;

   assign fetch_idx   = imemaddr[IDX+1:2];
   assign fetch_tag   = imemaddr[31:IDX+2];
   assign rslv_idx    = rslv_pc[IDX+1:2];
   assign rslv_tag    = rslv_pc[31:IDX+2];
   assign update_en   = rslv_valid & ~halt;
   assign imemREN     = ~halt;
   assign unused_bits = ^rslv_pc[1:0];

   always_comb begin
      pred_taken  = 1'b0;
      pred_target = '0;
      if (btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag)
          && btb_ctr[fetch_idx][CTR_BITS-1]) begin
         pred_taken  = 1'b1;
         pred_target = btb_target[fetch_idx];
      end
   end

   always_comb begin
      rslv_hit = btb_valid[rslv_idx] && (btb_tag[rslv_idx] == rslv_tag);
      ctr_next = btb_ctr[rslv_idx];
      if (rslv_taken) begin
         if (btb_ctr[rslv_idx] != CTR_MAX) ctr_next = btb_ctr[rslv_idx] + 1'b1;
      end else begin
         if (btb_ctr[rslv_idx] != '0) ctr_next = btb_ctr[rslv_idx] - 1'b1;
      end
   end

   // A halted front end freezes the PC; a mispredict redirect beats any fetch advance.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         imemaddr <= PC_INIT;
      end else if (halt) begin
         imemaddr <= imemaddr;
      end else if (rslv_valid && rslv_mispredict) begin
         imemaddr <= rslv_next;
      end else if (ihit && !stall) begin
         imemaddr <= pred_taken ? pred_target : imemaddr + 32'd4;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         halt <= 1'b0;
      end else if (halt_in) begin
         halt <= 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         br_count <= '0;
         mp_count <= '0;
      end else if (update_en) begin
         if (br_count != 32'hFFFF_FFFF) br_count <= br_count + 32'd1;
         if (rslv_mispredict && (mp_count != 32'hFFFF_FFFF)) mp_count <= mp_count + 32'd1;
      end
   end

   // Not-taken misses never allocate, so cold branches don't evict useful entries.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_valid[i]  <= 1'b0;
            btb_tag[i]    <= '0;
            btb_target[i] <= '0;
            btb_ctr[i]    <= CTR_WEAK_N;
         end
      end else if (update_en) begin
         if (rslv_hit) begin
            btb_ctr[rslv_idx] <= ctr_next;
            if (rslv_taken) btb_target[rslv_idx] <= rslv_target;
         end else if (rslv_taken) begin
            btb_valid[rslv_idx]  <= 1'b1;
            btb_tag[rslv_idx]    <= rslv_tag;
            btb_target[rslv_idx] <= rslv_target;
            btb_ctr[rslv_idx]    <= CTR_WEAK_T;
         end
      end
   end

endmodule

// File: tb/tb_fetch_predict_unit.sv
// Bench for fetch_predict_unit: directed scenarios plus random traffic, all
// checked against a table-based model of the fetch/BTB behaviour.
module tb_fetch_predict_unit;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        ihit, stall, halt_in;
   logic        rslv_valid, rslv_taken, rslv_mispredict;
   logic [31:0] rslv_pc, rslv_target, rslv_next;
   logic [31:0] imemaddr, pred_target, br_count, mp_count;
   logic        imemREN, pred_taken, halt;

   int errors = 0;
   int checks = 0;

   // Model: 16 entries, 2-bit counters; predicted taken when counter >= 2.
   logic [31:0] m_pc, m_br, m_mp;
   logic        m_halt;
   logic        m_valid [16];
   logic [31:0] m_tag   [16];
   logic [31:0] m_tgt   [16];
   int          m_ctr   [16];

   fetch_predict_unit #(.PC_INIT(32'h0), .BTB_ENTRIES(16), .CTR_BITS(2)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .stall(stall), .halt_in(halt_in),
      .rslv_valid(rslv_valid), .rslv_pc(rslv_pc), .rslv_taken(rslv_taken),
      .rslv_target(rslv_target), .rslv_mispredict(rslv_mispredict),
      .rslv_next(rslv_next), .imemaddr(imemaddr), .imemREN(imemREN),
      .pred_taken(pred_taken), .pred_target(pred_target), .halt(halt),
      .br_count(br_count), .mp_count(mp_count));

   always #5 CLK = ~CLK;

   function automatic int slot(input logic [31:0] pc);
      return int'((pc >> 2) % 16);
   endfunction

   function automatic void mpred(input logic [31:0] pc, output logic t, output logic [31:0] tg);
      int i;
      i  = slot(pc);
      t  = m_valid[i] && (m_tag[i] == (pc >> 6)) && (m_ctr[i] >= 2);
      tg = t ? m_tgt[i] : 32'h0;
   endfunction

   task automatic model_reset();
      m_pc = 32'h0; m_br = 0; m_mp = 0; m_halt = 1'b0;
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
      end
   endtask

   task automatic clear_inputs();
      ihit = 0; stall = 0; halt_in = 0; rslv_valid = 0; rslv_taken = 0;
      rslv_mispredict = 0; rslv_pc = 0; rslv_target = 0; rslv_next = 0;
   endtask

   task automatic drive_resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                                input logic mp, input logic [31:0] nxt);
      rslv_valid = 1; rslv_pc = pc; rslv_taken = tk; rslv_target = tgt;
      rslv_mispredict = mp; rslv_next = nxt;
   endtask

   // Advance the model by one edge using the inputs currently driven, then clock the DUT.
   task automatic tick();
      logic        pt;
      logic [31:0] ptg, nxt;
      int          i;
      mpred(m_pc, pt, ptg);
      nxt = m_pc;
      if (!m_halt) begin
         if (rslv_valid && rslv_mispredict) nxt = rslv_next;
         else if (ihit && !stall)           nxt = pt ? ptg : m_pc + 32'd4;
      end
      if (rslv_valid && !m_halt) begin
         i = slot(rslv_pc);
         if (m_valid[i] && m_tag[i] == (rslv_pc >> 6)) begin
            if (rslv_taken) begin
               m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
               m_tgt[i] = rslv_target;
            end else begin
               m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
         end else if (rslv_taken) begin
            m_valid[i] = 1'b1; m_tag[i] = rslv_pc >> 6; m_tgt[i] = rslv_target; m_ctr[i] = 2;
         end
         if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
         if (rslv_mispredict && m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 1;
      end
      if (halt_in) m_halt = 1'b1;
      m_pc = nxt;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      nRST = 1'b0;
      #2;
      model_reset();
      checks++; if (imemaddr !== 32'h0) begin errors++; $display("FAIL rst_pc actual=%h required=%h", imemaddr, 32'h0); end
      checks++; if (halt !== 1'b0 || imemREN !== 1'b1) begin errors++; $display("FAIL rst_halt actual=%b/%b required=0/1", halt, imemREN); end
      checks++; if (br_count !== 0 || mp_count !== 0) begin errors++; $display("FAIL rst_counts actual=%0d/%0d required=0/0", br_count, mp_count); end
      checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin errors++; $display("FAIL rst_pred actual=%b/%h required=0/0", pred_taken, pred_target); end
      nRST = 1'b1;
   endtask

   task automatic test_sequential();
      ihit = 1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         checks++; if (imemaddr !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc actual=%h required=%h", imemaddr, 32'(4 * i)); end
         checks++; if (pred_taken !== 1'b0 || imemREN !== 1'b1) begin errors++; $display("FAIL seq_pred actual=%b/%b required=0/1", pred_taken, imemREN); end
      end
   endtask

   task automatic test_stall();
      ihit = 1; stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (imemaddr !== 32'h20) begin errors++; $display("FAIL stall_hold actual=%h required=%h", imemaddr, 32'h20); end
      end
      stall = 0;
      tick();
      checks++; if (imemaddr !== 32'h24) begin errors++; $display("FAIL stall_release actual=%h required=%h", imemaddr, 32'h24); end
      clear_inputs();
   endtask

   task automatic test_redirect();
      ihit = 1;
      drive_resolve(32'h40, 1, 32'h100, 1, 32'h100);
      tick();
      checks++; if (imemaddr !== 32'h100) begin errors++; $display("FAIL redir_pc actual=%h required=%h", imemaddr, 32'h100); end
      checks++; if (mp_count !== 1 || br_count !== 1) begin errors++; $display("FAIL redir_counts actual=%0d/%0d required=1/1", mp_count, br_count); end
      clear_inputs();
      drive_resolve(32'h7000, 0, 32'h0, 1, 32'h40);
      tick();
      clear_inputs();
      checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h100) begin errors++; $display("FAIL btb_pred actual=%b/%h required=1/100", pred_taken, pred_target); end
      ihit = 1;
      tick();
      checks++; if (imemaddr !== 32'h100) begin errors++; $display("FAIL btb_follow actual=%h required=%h", imemaddr, 32'h100); end
      clear_inputs();
   endtask

   task automatic test_hysteresis();
      logic exp_t [4];
      logic tk [4];
      exp_t = '{1'b0, 1'b0, 1'b0, 1'b1};
      tk    = '{1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         drive_resolve(32'h40, tk[i], 32'h100, i == 0, 32'h40);
         tick();
         clear_inputs();
         checks++; if (pred_taken !== exp_t[i]) begin errors++; $display("FAIL hyst_%0d actual=%b required=%b", i, pred_taken, exp_t[i]); end
      end
      checks++; if (pred_target !== 32'h100) begin errors++; $display("FAIL hyst_target actual=%h required=%h", pred_target, 32'h100); end
   endtask

   task automatic test_alias();
      drive_resolve(32'h80, 0, 32'h0, 1, 32'h80);
      tick();
      clear_inputs();
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_miss actual=%b required=0", pred_taken); end
      // Allocation seen in the same cycle still shows the old entry.
      drive_resolve(32'h80, 1, 32'h200, 0, 32'h0);
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_same_cycle actual=%b required=0", pred_taken); end
      tick();
      clear_inputs();
      checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin errors++; $display("FAIL alias_alloc actual=%b/%h required=1/200", pred_taken, pred_target); end
      drive_resolve(32'h7000, 0, 32'h0, 1, 32'h40);
      tick();
      clear_inputs();
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_evicted actual=%b required=0", pred_taken); end
   endtask

   task automatic test_wrap();
      drive_resolve(32'h7000, 0, 32'h0, 1, 32'hFFFF_FFFC);
      tick();
      clear_inputs();
      ihit = 1;
      tick();
      clear_inputs();
      checks++; if (imemaddr !== 32'h0) begin errors++; $display("FAIL wrap_pc actual=%h required=%h", imemaddr, 32'h0); end
   endtask

   task automatic test_random();
      logic [31:0] pool [6];
      pool = '{32'h40, 32'h44, 32'h80, 32'hC0, 32'h100, 32'h140};
      for (int n = 0; n < 400; n++) begin
         logic        pt;
         logic [31:0] ptg;
         clear_inputs();
         ihit  = ($urandom_range(0, 9) < 7);
         stall = ($urandom_range(0, 9) < 2);
         if ($urandom_range(0, 1) == 1) begin
            drive_resolve(($urandom_range(0, 3) == 0) ? m_pc : pool[$urandom_range(0, 5)],
                          1'($urandom_range(0, 1)), pool[$urandom_range(0, 5)],
                          ($urandom_range(0, 3) == 0), pool[$urandom_range(0, 5)]);
         end
         mpred(m_pc, pt, ptg);
         checks++; if (pred_taken !== pt || pred_target !== ptg) begin errors++; $display("FAIL rnd_pred cyc=%0d actual=%b/%h required=%b/%h", n, pred_taken, pred_target, pt, ptg); end
         tick();
         checks++; if (imemaddr !== m_pc) begin errors++; $display("FAIL rnd_pc cyc=%0d actual=%h required=%h", n, imemaddr, m_pc); end
         checks++; if (br_count !== m_br || mp_count !== m_mp) begin errors++; $display("FAIL rnd_counts cyc=%0d actual=%0d/%0d required=%0d/%0d", n, br_count, mp_count, m_br, m_mp); end
      end
      clear_inputs();
   endtask

   task automatic test_halt();
      logic [31:0] br_hold;
      drive_resolve(32'h7000, 0, 32'h0, 1, 32'h30);
      tick();
      clear_inputs();
      halt_in = 1; ihit = 1;
      tick();
      clear_inputs();
      checks++; if (halt !== 1'b1 || imemREN !== 1'b0) begin errors++; $display("FAIL halt_set actual=%b/%b required=1/0", halt, imemREN); end
      checks++; if (imemaddr !== 32'h34) begin errors++; $display("FAIL halt_pc actual=%h required=%h", imemaddr, 32'h34); end
      br_hold = br_count;
      for (int i = 0; i < 3; i++) begin
         ihit = 1;
         drive_resolve(32'h40, 1, 32'h900, 1, 32'h900);
         tick();
         checks++; if (imemaddr !== 32'h34) begin errors++; $display("FAIL halt_frozen actual=%h required=%h", imemaddr, 32'h34); end
         checks++; if (br_count !== br_hold || br_count !== m_br) begin errors++; $display("FAIL halt_count actual=%0d required=%0d", br_count, br_hold); end
      end
      clear_inputs();
   endtask

   task automatic test_halt_redirect();
      halt_in = 1; ihit = 1;
      drive_resolve(32'h7000, 0, 32'h0, 1, 32'h500);
      tick();
      clear_inputs();
      checks++; if (imemaddr !== 32'h500 || halt !== 1'b1) begin errors++; $display("FAIL halt_redir actual=%h/%b required=500/1", imemaddr, halt); end
      ihit = 1;
      tick();
      clear_inputs();
      checks++; if (imemaddr !== 32'h500) begin errors++; $display("FAIL halt_redir_hold actual=%h required=%h", imemaddr, 32'h500); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_hysteresis();
      test_alias();
      test_wrap();
      test_random();
      test_halt();
      test_reset();
      test_halt_redirect();
      test_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
